// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Default pattern/length plus length-width and clamp helpers.
package seq_det_pkg;

    localparam logic [3:0] DEFAULT_PAT = 4'b1011;
    localparam int         DEFAULT_LEN = 4;

    // Width needed to hold a length value 0..pat_w inclusive.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at all-ones once reached.
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !(&r_cnt))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;
    assign o_sat = &r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// Mealy and registered match outputs, and a saturating match counter.
import seq_det_pkg::*;

module seq_detector_param #(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(seq_det_pkg::DEFAULT_PAT),
    parameter int               DEFAULT_LEN = seq_det_pkg::DEFAULT_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic                         i_seq,
    input  logic                         i_load,
    input  logic [PAT_W-1:0]             i_pat,
    input  logic [$clog2(PAT_W+1)-1:0]   i_len,
    input  logic                         i_overlap,
    input  logic                         i_clr_cnt,
    output logic                         o_det,
    output logic                         o_det_q,
    output logic [CNT_W-1:0]             o_cnt,
    output logic                         o_cnt_sat
);

    localparam int LEN_W = len_w(PAT_W);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic             r_det_q;

    logic [PAT_W-1:0] w_win;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W:0]   w_fill_inc;
    logic             w_match;
    logic             w_det;

    assign w_win = {r_hist[PAT_W-2:0], i_seq};

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < PAT_W; k++)
            w_mask[k] = (k < int'(r_len));
    end

    // fill gates the compare so bits consumed by a non-overlapping match,
    // or bits from before a flush, can never complete a new match.
    assign w_fill_inc = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_match    = (((w_win ^ r_pat) & w_mask) == '0) && (w_fill_inc >= {1'b0, r_len});
    assign w_det      = i_valid & ~i_load & ~rst & w_match & (r_len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= DEFAULT_PAT;
            r_len  <= LEN_W'(clamp_len(DEFAULT_LEN, PAT_W));
            r_ovl  <= 1'b1;
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_load) begin
            r_pat  <= i_pat;
            r_len  <= LEN_W'(clamp_len(int'(i_len), PAT_W));
            r_ovl  <= i_overlap;
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_valid) begin
            r_hist <= w_win;
            if (w_det && !r_ovl)
                r_fill <= '0;
            else if (r_fill != LEN_W'(PAT_W))
                r_fill <= r_fill + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_det_q <= 1'b0;
        else
            r_det_q <= w_det;
    end

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_det),
        .i_clr (i_clr_cnt),
        .o_cnt (o_cnt),
        .o_sat (o_cnt_sat)
    );

    assign o_det   = w_det;
    assign o_det_q = r_det_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param (PAT_W=4, CNT_W=2 so saturation is reachable).
// Inputs change on the falling edge; o_det is sampled before the rising edge, registered outputs just after.
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_seq = 1'b0;
    logic             i_load = 1'b0;
    logic [PAT_W-1:0] i_pat = '0;
    logic [2:0]       i_len = '0;
    logic             i_overlap = 1'b0;
    logic             i_clr_cnt = 1'b0;
    logic             o_det;
    logic             o_det_q;
    logic [CNT_W-1:0] o_cnt;
    logic             o_cnt_sat;

    int n_vec = 0;
    int n_err = 0;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_seq     (i_seq),
        .i_load    (i_load),
        .i_pat     (i_pat),
        .i_len     (i_len),
        .i_overlap (i_overlap),
        .i_clr_cnt (i_clr_cnt),
        .o_det     (o_det),
        .o_det_q   (o_det_q),
        .o_cnt     (o_cnt),
        .o_cnt_sat (o_cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic s, input logic clr);
        @(negedge clk);
        i_load = 1'b0; i_valid = v; i_seq = s; i_clr_cnt = clr;
        #1;
    endtask

    task automatic load_cfg(input logic [3:0] pat, input logic [2:0] len, input logic ovl);
        @(negedge clk);
        i_load = 1'b1; i_pat = pat; i_len = len; i_overlap = ovl;
        i_valid = 1'b0; i_clr_cnt = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clr_cnt();
        @(negedge clk);
        i_load = 1'b0; i_valid = 1'b0; i_clr_cnt = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_load = 1'b0; i_valid = 1'b0; i_clr_cnt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b1; i_seq = 1'b1;
        #1;
        n_vec++; if (o_det !== 1'b0) begin n_err++; $display("FAIL reset_det got %b want 0", o_det); end
        @(posedge clk); #1;
        n_vec++; if (o_det_q !== 1'b0) begin n_err++; $display("FAIL reset_det_q got %b want 0", o_det_q); end
        n_vec++; if (o_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", o_cnt); end
        n_vec++; if (o_cnt_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat got %b want 0", o_cnt_sat); end
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0; i_seq = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0);
            n_vec++; if (o_det !== exp[i]) begin n_err++; $display("FAIL ovl_det bit%0d got %b want %b", 7-i, o_det, exp[i]); end
            @(posedge clk); #1;
            n_vec++; if (o_det_q !== exp[i]) begin n_err++; $display("FAIL ovl_det_q bit%0d got %b want %b", 7-i, o_det_q, exp[i]); end
        end
        n_vec++; if (o_cnt !== 2'd2) begin n_err++; $display("FAIL ovl_cnt got %0d want 2", o_cnt); end
    endtask

    task automatic test_nonoverlap();
        logic [10:0] bits = 11'b10110111011;
        logic [10:0] exp  = 11'b00010000001;
        load_cfg(4'b1011, 3'd4, 1'b0);
        clr_cnt();
        for (int i = 10; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0);
            n_vec++; if (o_det !== exp[i]) begin n_err++; $display("FAIL novl_det bit%0d got %b want %b", 11-i, o_det, exp[i]); end
            @(posedge clk); #1;
        end
        n_vec++; if (o_cnt !== 2'd2) begin n_err++; $display("FAIL novl_cnt got %0d want 2", o_cnt); end
    endtask

    task automatic test_short_pattern();
        logic [3:0] exp_o = 4'b0111;
        logic [3:0] exp_n = 4'b0101;
        load_cfg(4'b0011, 3'd2, 1'b1);
        clr_cnt();
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, 1'b1, 1'b0);
            n_vec++; if (o_det !== exp_o[i]) begin n_err++; $display("FAIL p11_ovl bit%0d got %b want %b", 4-i, o_det, exp_o[i]); end
            @(posedge clk); #1;
        end
        n_vec++; if (o_cnt !== 2'd3 || o_cnt_sat !== 1'b1) begin n_err++; $display("FAIL p11_cnt got %0d/%b want 3/1", o_cnt, o_cnt_sat); end
        load_cfg(4'b0011, 3'd2, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, 1'b1, 1'b0);
            n_vec++; if (o_det !== exp_n[i]) begin n_err++; $display("FAIL p11_novl bit%0d got %b want %b", 4-i, o_det, exp_n[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_gaps();
        logic [6:0] vld  = 7'b1100011;
        logic [6:0] bits = 7'b1000011;
        logic [6:0] exp  = 7'b0000001;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive(vld[i], bits[i], 1'b0);
            n_vec++; if (o_det !== exp[i]) begin n_err++; $display("FAIL gap_det step%0d got %b want %b", 7-i, o_det, exp[i]); end
            @(posedge clk); #1;
            n_vec++; if (o_det_q !== exp[i]) begin n_err++; $display("FAIL gap_det_q step%0d got %b want %b", 7-i, o_det_q, exp[i]); end
        end
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_vec++; if (o_det_q !== 1'b0) begin n_err++; $display("FAIL gap_det_q_fall got %b want 0", o_det_q); end
    endtask

    task automatic test_saturation();
        logic [15:0] bits = 16'b1011011011011011;
        logic [15:0] exp  = 16'b0001001001001001;
        do_reset();
        for (int i = 15; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0);
            n_vec++; if (o_det !== exp[i]) begin n_err++; $display("FAIL sat_det bit%0d got %b want %b", 16-i, o_det, exp[i]); end
            @(posedge clk); #1;
        end
        n_vec++; if (o_cnt !== 2'd3 || o_cnt_sat !== 1'b1) begin n_err++; $display("FAIL sat_cnt got %0d/%b want 3/1", o_cnt, o_cnt_sat); end
        drive(1'b1, 1'b0, 1'b0); @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0); @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1);
        n_vec++; if (o_det !== 1'b1) begin n_err++; $display("FAIL clr_det got %b want 1", o_det); end
        @(posedge clk); #1;
        n_vec++; if (o_cnt !== 2'd0 || o_cnt_sat !== 1'b0) begin n_err++; $display("FAIL clr_cnt got %0d/%b want 0/0", o_cnt, o_cnt_sat); end
    endtask

    task automatic test_boundaries();
        logic [2:0] b1 = 3'b010;
        logic [2:0] e1 = 3'b101;
        logic [3:0] b4 = 4'b1011;
        logic [3:0] e4 = 4'b0001;
        load_cfg(4'b0000, 3'd1, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            drive(1'b1, b1[i], 1'b0);
            n_vec++; if (o_det !== e1[i]) begin n_err++; $display("FAIL len1 bit%0d got %b want %b", 3-i, o_det, e1[i]); end
            @(posedge clk); #1;
        end
        load_cfg(4'b1011, 3'd0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, b4[i], 1'b0);
            n_vec++; if (o_det !== 1'b0) begin n_err++; $display("FAIL len0 bit%0d got %b want 0", 4-i, o_det); end
            @(posedge clk); #1;
        end
        load_cfg(4'b1011, 3'd7, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, b4[i], 1'b0);
            n_vec++; if (o_det !== e4[i]) begin n_err++; $display("FAIL len_clamp bit%0d got %b want %b", 4-i, o_det, e4[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_and_reset();
        logic [3:0] b0 = 4'b0110;
        logic [3:0] bd = 4'b1011;
        logic [3:0] ex = 4'b0001;
        do_reset();
        clr_cnt();
        drive(1'b1, 1'b1, 1'b0); @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0); @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0); @(posedge clk); #1;
        @(negedge clk);
        i_load = 1'b1; i_pat = 4'b0110; i_len = 3'd4; i_overlap = 1'b1; i_valid = 1'b1; i_seq = 1'b1;
        #1;
        n_vec++; if (o_det !== 1'b0) begin n_err++; $display("FAIL load_det got %b want 0", o_det); end
        @(posedge clk); #1;
        n_vec++; if (o_cnt !== 2'd0) begin n_err++; $display("FAIL load_cnt got %0d want 0", o_cnt); end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, b0[i], 1'b0);
            n_vec++; if (o_det !== ex[i]) begin n_err++; $display("FAIL newpat bit%0d got %b want %b", 4-i, o_det, ex[i]); end
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (o_det_q !== 1'b0 || o_cnt !== 2'd0 || o_det !== 1'b0) begin
            n_err++; $display("FAIL async_rst got det_q=%b cnt=%0d det=%b want 0/0/0", o_det_q, o_cnt, o_det);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, bd[i], 1'b0);
            n_vec++; if (o_det !== ex[i]) begin n_err++; $display("FAIL post_rst bit%0d got %b want %b", 4-i, o_det, ex[i]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_short_pattern();
        test_gaps();
        test_saturation();
        test_boundaries();
        test_load_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
